serial_adder: RTL

Bit-serial two's-complement adder/subtractor that sits directly upstream of the team's one-bit full adder cell. It feeds that cell one bit pair per clock, LSB first, and registers the carry between bits. It assembles the WIDTH-bit result in a shift register and returns it with flags over a valid/ready handshake. The block trades WIDTH cycles of latency for a single full-adder cell.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_fa.sv | 20 ++
 rtl/serial_adder.sv | 115 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit gate-level full adder cell; the only carry logic in the serial adder.
module structuralFullAdder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output wire  s_o,
  output wire  cout_o
);

  wire axb_s;
  wire ab_s;
  wire cx_s;

  xor g_axb  (axb_s, a_i, b_i);
  xor g_sum  (s_o, axb_s, cin_i);
  and g_ab   (ab_s, a_i, b_i);
  and g_cx   (cx_s, axb_s, cin_i);
  or  g_cout (cout_o, ab_s, cx_s);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder/subtractor: one bit pair per clock, LSB first,
// through a single full-adder cell, result returned over a valid/ready handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MSB_CIN = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] sum_sr_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             carry_q;
  logic             msb_cin_q;
  logic             carryout_q;
  logic             overflow_q;

  logic [WIDTH-1:0] a_sr_d;
  logic [WIDTH-1:0] b_sr_d;
  logic [WIDTH-1:0] sum_sr_d;
  logic [CNT_W-1:0] bit_cnt_d;
  wire              fa_sum_s;
  wire              fa_cout_s;

  structuralFullAdder u_fa (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_sum_s),
    .cout_o (fa_cout_s)
  );

  // Operands drain right; each new sum bit enters at the MSB so the result ends LSB-aligned.
  assign a_sr_d    = {1'b0, a_sr_q[WIDTH-1:1]};
  assign b_sr_d    = {1'b0, b_sr_q[WIDTH-1:1]};
  assign sum_sr_d  = {fa_sum_s, sum_sr_q[WIDTH-1:1]};
  assign bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sr_q     <= {WIDTH{1'b0}};
      b_sr_q     <= {WIDTH{1'b0}};
      sum_sr_q   <= {WIDTH{1'b0}};
      bit_cnt_q  <= {CNT_W{1'b0}};
      carry_q    <= 1'b0;
      msb_cin_q  <= 1'b0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sr_q    <= a;
            b_sr_q    <= sub ? ~b : b;
            carry_q   <= sub;
            bit_cnt_q <= {CNT_W{1'b0}};
            state_q   <= RUN;
          end
        end
        RUN: begin
          sum_sr_q  <= sum_sr_d;
          a_sr_q    <= a_sr_d;
          b_sr_q    <= b_sr_d;
          carry_q   <= fa_cout_s;
          bit_cnt_q <= bit_cnt_d;
          if (bit_cnt_q == CNT_MSB_CIN) begin
            msb_cin_q <= fa_cout_s;
          end
          if (bit_cnt_q == CNT_LAST) begin
            carryout_q <= fa_cout_s;
            overflow_q <= msb_cin_q ^ fa_cout_s;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_sr_q;
  assign carryout  = carryout_q;
  assign overflow  = overflow_q;
  assign zero      = (sum_sr_q == {WIDTH{1'b0}});

endmodule
